arbiter_wrr: RTL

//  Parametrised weighted round-robin arbiter with grant lock, the next generation of the

---
 rtl/arbiter_wrr_if.sv | 26 ++
 rtl/arbiter_wrr.sv | 137 +++++++++++++
 2 files changed

// File: rtl/arbiter_wrr_if.sv
// Request/grant bundle between a group of requesters and the weighted round-robin arbiter.
// The master side drives requests and control; the slave side (the arbiter) returns grants.
interface arbiter_wrr_if #(
  parameter int NUM_REQUEST     = 4,
  parameter int WEIGHT_WIDTH    = 4,
  parameter int REQ_INDEX_WIDTH = $clog2(NUM_REQUEST) + 1
);
  logic                                init_in;
  logic                                en_in;
  logic                                mode_in;
  logic [NUM_REQUEST-1:0]              req_in;
  logic [NUM_REQUEST*WEIGHT_WIDTH-1:0] weight_in;
  logic                                granted_out;
  logic [NUM_REQUEST-1:0]              grant_out;
  logic [REQ_INDEX_WIDTH-1:0]          grant_idx_out;

  modport master (
    output init_in, en_in, mode_in, req_in, weight_in,
    input  granted_out, grant_out, grant_idx_out
  );

  modport slave (
    input  init_in, en_in, mode_in, req_in, weight_in,
    output granted_out, grant_out, grant_idx_out
  );
endinterface

// File: rtl/arbiter_wrr.sv
// Weighted round-robin / fixed-priority arbiter with grant lock, optional hold timeout
// and back-to-back re-arbitration when the current owner releases.
module arbiter_wrr #(
  parameter int NUM_REQUEST     = 4,
  parameter int REQ_INDEX_WIDTH = $clog2(NUM_REQUEST) + 1,
  parameter int WEIGHT_WIDTH    = 4,
  parameter int HOLD_LIMIT      = 0
) (
  input  logic         clk,
  input  logic         rst,
  arbiter_wrr_if.slave arb
);
  localparam int IDX_W  = (NUM_REQUEST > 1) ? $clog2(NUM_REQUEST) : 1;
  localparam int HOLD_W = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_LIMIT > 0) ? HOLD_LIMIT - 1 : 0);
  localparam logic [IDX_W-1:0]  PTR_RESET = IDX_W'(NUM_REQUEST - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                                   state_q, state_d;
  logic [IDX_W-1:0]                         owner_q, owner_d;
  logic [IDX_W-1:0]                         ptr_q, ptr_d;
  logic [HOLD_W-1:0]                        hold_q, hold_d;
  logic [NUM_REQUEST-1:0][WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic [NUM_REQUEST-1:0][WEIGHT_WIDTH-1:0] eff_weight;
  logic [NUM_REQUEST-1:0][WEIGHT_WIDTH-1:0] credit_work;
  logic [NUM_REQUEST-1:0]                   owner_oh, masked, cand, eligible;
  logic                                     hold_hit, release_now, keep_owner, try_grant;
  logic                                     win_found;
  logic [IDX_W-1:0]                         win_idx, search_base, pos;

  // A zero weight still earns one grant per round.
  always_comb begin
    eff_weight = '0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      eff_weight[i] = arb.weight_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      if (eff_weight[i] == '0) eff_weight[i] = WEIGHT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    credit_d = credit_q;

    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    masked      = arb.req_in & ~owner_oh;
    hold_hit    = (HOLD_LIMIT != 0) && (hold_q == HOLD_LAST);
    release_now = (state_q == LOCK) && (!arb.req_in[owner_q] || hold_hit);
    // In WRR mode an owner with credit left competes again, so weights survive hold timeouts.
    keep_owner  = arb.mode_in && (credit_q[owner_q] != '0);

    cand = '0;
    if (state_q == IDLE)
      cand = arb.req_in;
    else if (release_now)
      cand = ((masked == '0) || keep_owner) ? arb.req_in : masked;
    try_grant = arb.en_in && (cand != '0);

    credit_work = credit_q;
    eligible    = '0;
    for (int i = 0; i < NUM_REQUEST; i++)
      eligible[i] = cand[i] && (credit_q[i] != '0);
    if (!arb.mode_in) begin
      eligible = cand;
    end else if (try_grant && (eligible == '0)) begin
      credit_work = eff_weight;
      eligible    = cand;
    end

    // Fixed priority is a cyclic search that always starts just after the last index.
    search_base = arb.mode_in ? ptr_q : PTR_RESET;
    win_found   = 1'b0;
    win_idx     = '0;
    pos         = '0;
    for (int k = 1; k <= NUM_REQUEST; k++) begin
      pos = IDX_W'((int'(search_base) + k) % NUM_REQUEST);
      if (!win_found && eligible[pos]) begin
        win_found = 1'b1;
        win_idx   = pos;
      end
    end

    if (try_grant && win_found) begin
      state_d = LOCK;
      owner_d = win_idx;
      hold_d  = '0;
      if (arb.mode_in) begin
        credit_d          = credit_work;
        credit_d[win_idx] = credit_work[win_idx] - WEIGHT_WIDTH'(1);
        if (credit_work[win_idx] == WEIGHT_WIDTH'(1)) ptr_d = win_idx;
      end
    end else if ((state_q == LOCK) && !release_now) begin
      hold_d = (HOLD_LIMIT != 0) ? hold_q + HOLD_W'(1) : '0;
    end else begin
      state_d = IDLE;
    end

    if (arb.init_in) begin
      state_d  = IDLE;
      credit_d = eff_weight;
      ptr_d    = PTR_RESET;
      hold_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= PTR_RESET;
      hold_q   <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      credit_q <= credit_d;
    end
  end

  // Outputs decode straight from registers, so an async reset clears them at once.
  always_comb begin
    arb.granted_out   = (state_q == LOCK);
    arb.grant_out     = '0;
    arb.grant_idx_out = '0;
    if (state_q == LOCK) begin
      arb.grant_out[owner_q] = 1'b1;
      arb.grant_idx_out      = REQ_INDEX_WIDTH'(owner_q) + REQ_INDEX_WIDTH'(1);
    end
  end
endmodule
